// File: rtl/fractal_lane_array.sv
// N-lane escape-time pixel engine: round-robin dispatch, in-order collect onto a 24-bit RGB stream.
// Latency count+2 cycles per pixel; pix_tready low holds the head lane, lanes fill, dispatcher stalls.
module fractal_lane_array #(
  parameter int N_LANES   = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic                     cfg_julia,
  input  logic [7:0]               cfg_max_iter,
  input  logic signed [DATA_W-1:0] cfg_c_re,
  input  logic signed [DATA_W-1:0] cfg_c_im,
  input  logic signed [DATA_W-1:0] cfg_origin_re,
  input  logic signed [DATA_W-1:0] cfg_origin_im,
  input  logic signed [DATA_W-1:0] cfg_step_re,
  input  logic signed [DATA_W-1:0] cfg_step_im,
  input  logic [7:0]               cfg_g_mul,
  input  logic [7:0]               cfg_b_mul,
  output logic [23:0]              pix_tdata,
  output logic                     pix_tvalid,
  input  logic                     pix_tready,
  output logic                     pix_sof,
  output logic                     pix_eol,
  output logic                     busy
);

  localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int PRW = 2 * DATA_W;
  localparam int SW  = 2 * DATA_W + 2;
  localparam logic signed [PRW:0]  ESC_LIM = (PRW + 1)'(4 << FRAC_BITS);
  localparam logic signed [SW-1:0] SAT_HI  = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO  = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {L_IDLE, L_ITER, L_DONE} lane_st_e;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SAT_LO) return {1'b1, {(DATA_W-1){1'b0}}};
    else                 return v[DATA_W-1:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_LANES - 1)) ? '0 : p + 1'b1;
  endfunction

  // shadow configuration, captured when pixel (0,0) is issued
  logic                     sh_julia;
  logic [7:0]               sh_max_iter, sh_g_mul, sh_b_mul;
  logic signed [DATA_W-1:0] sh_c_re, sh_c_im, sh_org_re, sh_org_im, sh_step_re, sh_step_im;

  logic                     eff_julia;
  logic [7:0]               eff_max_iter, eff_g_mul, eff_b_mul;
  logic signed [DATA_W-1:0] eff_c_re, eff_c_im, eff_org_re, eff_org_im, eff_step_re, eff_step_im;

  logic [PW-1:0]            disp_ptr, col_ptr;
  logic [XW-1:0]            x_cnt;
  logic [YW-1:0]            y_cnt;
  logic signed [DATA_W-1:0] cx_r, cy_r, issue_cx, issue_cy;
  logic                     first_px, last_x, last_y, issue, hs;

  lane_st_e    lane_st_a  [N_LANES];
  logic [23:0] lane_rgb_a [N_LANES];
  logic        lane_sof_a [N_LANES];
  logic        lane_eol_a [N_LANES];

  assign first_px = (x_cnt == '0) && (y_cnt == '0);
  assign last_x   = (x_cnt == XW'(X_SIZE - 1));
  assign last_y   = (y_cnt == YW'(Y_SIZE - 1));
  assign issue    = enable && (lane_st_a[disp_ptr] == L_IDLE);
  assign hs       = pix_tvalid && pix_tready;

  always_comb begin
    eff_julia    = first_px ? cfg_julia     : sh_julia;
    eff_max_iter = first_px ? cfg_max_iter  : sh_max_iter;
    eff_g_mul    = first_px ? cfg_g_mul     : sh_g_mul;
    eff_b_mul    = first_px ? cfg_b_mul     : sh_b_mul;
    eff_c_re     = first_px ? cfg_c_re      : sh_c_re;
    eff_c_im     = first_px ? cfg_c_im      : sh_c_im;
    eff_org_re   = first_px ? cfg_origin_re : sh_org_re;
    eff_org_im   = first_px ? cfg_origin_im : sh_org_im;
    eff_step_re  = first_px ? cfg_step_re   : sh_step_re;
    eff_step_im  = first_px ? cfg_step_im   : sh_step_im;
    issue_cx     = (x_cnt == '0) ? eff_org_re : cx_r;
    issue_cy     = (y_cnt == '0) ? eff_org_im : cy_r;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sh_julia    <= 1'b0;
      sh_max_iter <= '0;
      sh_g_mul    <= '0;
      sh_b_mul    <= '0;
      sh_c_re     <= '0;
      sh_c_im     <= '0;
      sh_org_re   <= '0;
      sh_org_im   <= '0;
      sh_step_re  <= '0;
      sh_step_im  <= '0;
    end else if (issue && first_px) begin
      sh_julia    <= cfg_julia;
      sh_max_iter <= cfg_max_iter;
      sh_g_mul    <= cfg_g_mul;
      sh_b_mul    <= cfg_b_mul;
      sh_c_re     <= cfg_c_re;
      sh_c_im     <= cfg_c_im;
      sh_org_re   <= cfg_origin_re;
      sh_org_im   <= cfg_origin_im;
      sh_step_re  <= cfg_step_re;
      sh_step_im  <= cfg_step_im;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      disp_ptr <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      cx_r     <= '0;
      cy_r     <= '0;
    end else if (issue) begin
      disp_ptr <= ptr_inc(disp_ptr);
      cx_r     <= issue_cx + eff_step_re;
      if (last_x) begin
        x_cnt <= '0;
        y_cnt <= last_y ? '0 : y_cnt + 1'b1;
        cy_r  <= issue_cy + eff_step_im;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)  col_ptr <= '0;
    else if (hs) col_ptr <= ptr_inc(col_ptr);
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_st_e                 st, st_nxt;
    logic                     load, pop, esc, stop;
    logic signed [DATA_W-1:0] zr, zi, cr, ci, nzr, nzi;
    logic [7:0]               cnt, mi, gm, bm, gc, bc;
    logic [23:0]              rgb, col;
    logic                     sof_l, eol_l;
    logic signed [PRW-1:0]    zr_x, zi_x, rr, ii, ri;
    logic signed [PRW:0]      mag, dif, ri2, sh_re, sh_im;
    logic signed [SW-1:0]     sum_re, sum_im;

    assign load = issue && (disp_ptr == PW'(g));
    assign pop  = hs && (col_ptr == PW'(g));

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) st <= L_IDLE;
      else        st <= st_nxt;
    end

    always_comb begin
      st_nxt = st;
      case (st)
        L_IDLE:  if (load) st_nxt = L_ITER;
        L_ITER:  if (stop) st_nxt = L_DONE;
        L_DONE:  if (pop)  st_nxt = L_IDLE;
        default: st_nxt = L_IDLE;
      endcase
    end

    always_comb begin
      zr_x   = {{DATA_W{zr[DATA_W-1]}}, zr};
      zi_x   = {{DATA_W{zi[DATA_W-1]}}, zi};
      rr     = zr_x * zr_x;
      ii     = zi_x * zi_x;
      ri     = zr_x * zi_x;
      mag    = {rr[PRW-1], rr} + {ii[PRW-1], ii};
      dif    = {rr[PRW-1], rr} - {ii[PRW-1], ii};
      ri2    = {ri, 1'b0};
      esc    = (mag >>> FRAC_BITS) > ESC_LIM;
      stop   = esc || (cnt == mi);
      sh_re  = dif >>> FRAC_BITS;
      sh_im  = ri2 >>> FRAC_BITS;
      sum_re = {sh_re[PRW], sh_re} + {{(SW-DATA_W){cr[DATA_W-1]}}, cr};
      sum_im = {sh_im[PRW], sh_im} + {{(SW-DATA_W){ci[DATA_W-1]}}, ci};
      nzr    = sat(sum_re);
      nzi    = sat(sum_im);
      gc     = cnt * gm;
      bc     = cnt * bm;
      col    = (cnt == mi) ? 24'h000000 : {cnt, gc, bc};
    end

    // each lane keeps its own copy of the frame config so a new frame never retints old pixels
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        zr <= '0; zi <= '0; cr <= '0; ci <= '0;
        cnt <= '0; mi <= 8'd1; gm <= '0; bm <= '0;
        rgb <= '0; sof_l <= 1'b0; eol_l <= 1'b0;
      end else if (load) begin
        zr    <= eff_julia ? issue_cx : '0;
        zi    <= eff_julia ? issue_cy : '0;
        cr    <= eff_julia ? eff_c_re : issue_cx;
        ci    <= eff_julia ? eff_c_im : issue_cy;
        cnt   <= '0;
        mi    <= (eff_max_iter == 8'd0) ? 8'd1 : eff_max_iter;
        gm    <= eff_g_mul;
        bm    <= eff_b_mul;
        sof_l <= first_px;
        eol_l <= last_x;
      end else if (st == L_ITER) begin
        if (stop) begin
          rgb <= col;
        end else begin
          zr  <= nzr;
          zi  <= nzi;
          cnt <= cnt + 8'd1;
        end
      end
    end

    assign lane_st_a[g]  = st;
    assign lane_rgb_a[g] = rgb;
    assign lane_sof_a[g] = sof_l;
    assign lane_eol_a[g] = eol_l;
  end

  always_comb begin
    pix_tvalid = (lane_st_a[col_ptr] == L_DONE);
    pix_tdata  = pix_tvalid ? lane_rgb_a[col_ptr] : 24'h000000;
    pix_sof    = pix_tvalid && lane_sof_a[col_ptr];
    pix_eol    = pix_tvalid && lane_eol_a[col_ptr];
    busy       = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_st_a[i] != L_IDLE) busy = 1'b1;
    end
  end

endmodule

// File: doc/fractal_lane_array.md
Name: fractal_lane_array

Overview:
- Parametrised successor to the single/dual-engine pixel generator.
- N_LANES escape-time engines compute Mandelbrot or Julia pixels in parallel.
- A dispatcher hands out raster-order coordinates round-robin. A collector drains results in the same order onto a 24-bit RGB valid/ready stream with sof/eol markers, which feeds the packer.
- Configuration is shadowed at frame start, so mid-frame register writes never tear an image.

Parameters:
- N_LANES, 4: number of iteration engines (1..16).
- DATA_W, 16: signed fixed-point width of z, c, origin, step.
- FRAC_BITS, 8: fractional bits (1.0 = 1<<FRAC_BITS).
- X_SIZE, 640: pixels per line.
- Y_SIZE, 480: lines per frame.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  dispatcher may issue new pixels while high.
- cfg_julia  in  1  0=Mandelbrot, 1=Julia.
- cfg_max_iter  in  8  iteration cap; 0 treated as 1.
- cfg_c_re, cfg_c_im  in  DATA_W  Julia constant (signed).
- cfg_origin_re, cfg_origin_im  in  DATA_W  coordinate of pixel (0,0) (signed).
- cfg_step_re, cfg_step_im  in  DATA_W  per-pixel / per-line increment (signed).
- cfg_g_mul, cfg_b_mul  in  8  colour multipliers.
- pix_tdata  out  24  {R,G,B}.
- pix_tvalid  out  1  pixel available.
- pix_tready  in  1  downstream accepts.
- pix_sof  out  1  pixel is (0,0).
- pix_eol  out  1  pixel has x==X_SIZE-1.
- busy  out  1  any lane not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - All lanes IDLE; dispatch and collect pointers 0; dispatch x=y=0.
  - pix_tvalid=0, pix_tdata=0, pix_sof=0, pix_eol=0, busy=0.
  - Shadow config cleared; reset mid-frame discards all in-flight pixels.
- Shadow config: all cfg_* inputs are captured in the same cycle the dispatcher issues pixel (0,0). Lanes use only shadow values.
- Coordinates: cx = origin_re + x*step_re, cy = origin_im + y*step_im.
  - Computed incrementally: add step per pixel; reload origin at line/frame wrap.
  - Wraps modulo 2^DATA_W.
- Dispatcher:
  - Issues when enable=1 and lane[disp_ptr] is IDLE. Loads (cx, cy, x==X_SIZE-1, x==0&&y==0) into that lane.
  - Then advances x; on x==X_SIZE-1, x←0 and y advances; on y==Y_SIZE-1, y←0 (next frame).
  - disp_ptr increments modulo N_LANES. At most one issue per cycle.
- Lane FSM IDLE→ITER→DONE→IDLE:
  - Load: Mandelbrot z=0, c=(cx,cy); Julia z=(cx,cy), c=shadow c; count=0.
  - ITER, one step per cycle:
    - rr=zr*zr, ii=zi*zi, ri=zr*zi, each full 2*DATA_W signed.
    - Escape if ((rr+ii)>>>FRAC_BITS) > (4<<FRAC_BITS), or count==max_iter → DONE.
    - Else zr←sat((rr-ii)>>>FRAC_BITS + c_re), zi←sat((2*ri)>>>FRAC_BITS + c_im), count+1.
    - sat clamps to DATA_W signed range.
  - DONE holds the result until collected.
- Collector:
  - pix_tvalid=1 iff lane[col_ptr] is DONE. pix_tdata/sof/eol come from that lane (registered, stable while tvalid && !tready).
  - Colour: count==max_iter → 24'h000000; else R=count, G=(count*g_mul)[7:0], B=(count*b_mul)[7:0].
  - Handshake (tvalid&&tready): lane→IDLE, col_ptr+1 mod N_LANES.
  - A lane freed by handshake may be re-dispatched in the next cycle, not the same cycle.
- Ordering: output is strictly raster order regardless of per-lane iteration counts. A fast lane waits in DONE behind a slow one.
- Minimum latency from issue to tvalid = 2 cycles (load + one ITER check). Per-pixel latency = count+2.
- enable=0: no new issues; in-flight lanes finish and drain normally.
- Backpressure: pix_tready=0 indefinitely stalls the collector. Lanes fill to DONE; dispatcher stalls on the non-IDLE lane; nothing is lost or duplicated.
- busy=0 only when every lane is IDLE.

Test Plan:
- Params N_LANES=4, DATA_W=16, FRAC_BITS=8, X_SIZE=8, Y_SIZE=2.
- Mandelbrot, origin=(0,0), step=(0,0), max_iter=5, tready=1 → every pixel count=5, tdata=0. Exactly 16 pixels per frame; sof on 1st, eol on 8th and 16th.
- Mandelbrot, origin_re=0x0300 (3.0), step=0, g_mul=2, b_mul=3 → escape at count=1, tdata=24'h010203. Throughput ≥ 1 pixel per 3 cycles steady state.
- Mixed: step_re=0x0080, origin=(-2.0,0), max_iter=20 → output x order 0..7 matches a golden model bit-exactly, despite out-of-order lane completion.
- tready toggled randomly (50%), with 10 consecutive-cycle stalls → pixel sequence identical to the no-stall run. tdata stable while stalled.
- cfg_max_iter changed 5→20 mid-frame → remainder of frame uses 5; next frame (from sof) uses 20.
- areset pulsed while 3 lanes are in ITER → tvalid=0 immediately. After release the first output pixel has sof=1 and x=0.
